// File: rtl/mydesign_sweep_pkg.sv
// Shared types and helpers for the sweep driver: FSM state, default MISR polynomial,
// MISR step and popcount.
package mydesign_sweep_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} sweep_state_e;

   localparam logic [15:0] SigPolyDefault = 16'h1021;

   // Generic MISR step for widths up to 32 bits; bits at and above width are masked off.
   function automatic logic [31:0] misr_step(input logic [31:0]  sig,
                                             input logic [31:0]  poly,
                                             input logic [31:0]  data,
                                             input int unsigned  width);
      logic [31:0] mask;
      logic [31:0] nxt;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      nxt  = (sig << 1) ^ (sig[5'(width - 1)] ? poly : 32'd0) ^ data;
      return nxt & mask;
   endfunction

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/mydesign_sweep_misr.sv
// Multiple-input signature register with synchronous clear and enable.
module mydesign_sweep_misr
   import mydesign_sweep_pkg::*;
#(
   parameter int unsigned SIG_W    = 16,
   parameter logic [31:0] SIG_POLY = 32'(SigPolyDefault)
) (
   input  logic             clk_ci,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [SIG_W-1:0] data_i,
   output logic [SIG_W-1:0] sig_o
);

   logic [SIG_W-1:0] sig_q, sig_d;
   logic [31:0]      step;

   always_comb begin
      step  = misr_step(32'(sig_q), SIG_POLY, 32'(data_i), SIG_W);
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = step[SIG_W-1:0];
      end
   end

   always_ff @(posedge clk_ci or negedge rst_ni) begin
      if (!rst_ni) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/mydesign_sweep_driver.sv
// Exhaustive operand sweep with latency-aligned MISR capture of the DUT result.
// Optional result toggle counter enabled by `define MYDESIGN_SWEEP_TOGGLE_CNT_EN.
module mydesign_sweep_driver
   import mydesign_sweep_pkg::*;
#(
   parameter int unsigned N_IN     = 4,
   parameter int unsigned N_OUT    = 6,
   parameter int unsigned LATENCY  = 1,
   parameter int unsigned SIG_W    = 16,
   parameter logic [31:0] SIG_POLY = 32'(SigPolyDefault)
) (
   input  logic             clk_ci,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic [N_IN-1:0]  operand_a_o,
   output logic [N_IN-1:0]  operand_b_o,
   input  logic [N_OUT-1:0] result_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [SIG_W-1:0] signature_o,
   output logic [15:0]      toggle_cnt_o
);

   localparam int unsigned IdxW = 2 * N_IN;

   sweep_state_e       state_q, state_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic [LATENCY-1:0] vld_q, vld_d;
   logic               clr;
   logic               sample;

   assign sample = vld_q[LATENCY-1];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr     = 1'b0;
      // Valid pipe tracks in-flight operands; it empties exactly LATENCY cycles after RUN.
      vld_d   = LATENCY'({vld_q, (state_q == StRun)});
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               clr     = 1'b1;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (idx_q == '1) begin
               state_d = StDrain;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDrain: begin
            if (vld_d == '0) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_ci or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         idx_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
      end
   end

   assign operand_a_o = idx_q[IdxW-1:N_IN];
   assign operand_b_o = idx_q[N_IN-1:0];
   assign busy_o      = (state_q == StRun) || (state_q == StDrain);
   assign done_o      = (state_q == StDone);

   mydesign_sweep_misr #(
      .SIG_W    (SIG_W),
      .SIG_POLY (SIG_POLY)
   ) u_misr (
      .clk_ci (clk_ci),
      .rst_ni (rst_ni),
      .clr_i  (clr),
      .en_i   (sample),
      .data_i (SIG_W'(result_i)),
      .sig_o  (signature_o)
   );

`ifdef MYDESIGN_SWEEP_TOGGLE_CNT_EN
   logic [N_OUT-1:0] prev_q, prev_d;
   logic [15:0]      tog_q, tog_d;
   logic [16:0]      tog_sum;

   always_comb begin
      prev_d  = prev_q;
      tog_d   = tog_q;
      tog_sum = {1'b0, tog_q} + 17'(popcount(32'(result_i ^ prev_q)));
      if (clr) begin
         prev_d = '0;
         tog_d  = '0;
      end else if (sample) begin
         prev_d = result_i;
         tog_d  = tog_sum[16] ? 16'hFFFF : tog_sum[15:0];
      end
   end

   always_ff @(posedge clk_ci or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= '0;
         tog_q  <= '0;
      end else begin
         prev_q <= prev_d;
         tog_q  <= tog_d;
      end
   end

   assign toggle_cnt_o = tog_q;
`else
   assign toggle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mydesign_sweep_driver.sv
// Directed bench: two drivers (LATENCY 1 and 3) against behavioural registered-multiplier models.
module tb_mydesign_sweep_driver;

`ifdef MYDESIGN_SWEEP_TOGGLE_CNT_EN
   localparam bit TogEn = 1'b1;
`else
   localparam bit TogEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        use_model = 1'b0;
   logic [5:0]  res_drv = '0;

   logic [3:0]  a1, b1, a3, b3;
   logic [5:0]  res1, res3;
   logic        busy1, done1, busy3, done3;
   logic [15:0] sig1, sig3, tog1, tog3;

   logic [5:0]  m1, m3_0, m3_1, m3_2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] model_sig, alt_sig;
   logic [15:0] model_tog;

   always #5 clk = ~clk;

   // Behavioural stand-ins for the registered multiplier top, truncated to 6 bits.
   always_ff @(posedge clk) begin
      m1   <= 6'({4'b0, a1} * {4'b0, b1});
      m3_0 <= 6'({4'b0, a3} * {4'b0, b3});
      m3_1 <= m3_0;
      m3_2 <= m3_1;
   end

   assign res1 = use_model ? m1 : res_drv;
   assign res3 = m3_2;

   mydesign_sweep_driver u_dut1 (
      .clk_ci       (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .operand_a_o  (a1),
      .operand_b_o  (b1),
      .result_i     (res1),
      .busy_o       (busy1),
      .done_o       (done1),
      .signature_o  (sig1),
      .toggle_cnt_o (tog1)
   );

   mydesign_sweep_driver #(
      .LATENCY (3)
   ) u_dut3 (
      .clk_ci       (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .operand_a_o  (a3),
      .operand_b_o  (b3),
      .result_i     (res3),
      .busy_o       (busy3),
      .done_o       (done3),
      .signature_o  (sig3),
      .toggle_cnt_o (tog3)
   );

   function automatic logic [15:0] misr(input logic [15:0] s, input logic [5:0] r);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'd0, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 zero result, 1 result 1 on final sample only, 2 alternating 3F/00, 3 model
   task automatic run_sweep(input int mode, input int stray_c);
      int         bad_win;
      int         bad_ops;
      int         first_win;
      int         first_ops;
      logic       eb1, ed1, eb3, ed3;
      logic [7:0] exp_idx;
      bad_win   = 0;
      bad_ops   = 0;
      first_win = 0;
      first_ops = 0;
      use_model = (mode == 3);
      res_drv   = '0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 262; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("sig_cleared_on_start", 32'(sig1), 32'd0);
            chk("done_cleared_on_start", 32'(done1), 32'd0);
         end
         eb1 = (c <= 257);
         ed1 = (c >= 258);
         eb3 = (c <= 259);
         ed3 = (c >= 260);
         if (busy1 !== eb1 || done1 !== ed1 || busy3 !== eb3 || done3 !== ed3) begin
            if (bad_win == 0) first_win = c;
            bad_win++;
         end
         exp_idx = (c <= 256) ? 8'(c - 1) : 8'hFF;
         if ({a1, b1} !== exp_idx || {a3, b3} !== exp_idx) begin
            if (bad_ops == 0) first_ops = c;
            bad_ops++;
         end
         start = (c == stray_c);
         case (mode)
            1:       res_drv = (c == 257) ? 6'h01 : 6'h00;
            2:       res_drv = (c >= 2 && c <= 257 && (c % 2) == 0) ? 6'h3F : 6'h00;
            default: res_drv = 6'h00;
         endcase
      end
      chk($sformatf("busy_done_window(first bad cycle %0d)", first_win), bad_win, 0);
      chk($sformatf("operand_sequence(first bad cycle %0d)", first_ops), bad_ops, 0);
      chk("sig_latency3_model", 32'(sig3), 32'(model_sig));
      chk("tog_latency3_model", 32'(tog3), TogEn ? 32'(model_tog) : 32'd0);
   endtask

   initial begin
      logic [5:0] p, prev;
      model_sig = '0;
      alt_sig   = '0;
      model_tog = '0;
      prev      = '0;
      for (int i = 0; i < 256; i++) begin
         p         = 6'((i / 16) * (i % 16));
         model_sig = misr(model_sig, p);
         model_tog = model_tog + 16'($countones(p ^ prev));
         prev      = p;
         alt_sig   = misr(alt_sig, (i % 2 == 0) ? 6'h3F : 6'h00);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_operands", 32'({a1, b1}), 32'd0);
      chk("reset_busy", 32'(busy1), 32'd0);
      chk("reset_done", 32'(done1), 32'd0);
      chk("reset_sig", 32'(sig1), 32'd0);
      chk("reset_tog", 32'(tog1), 32'd0);
      chk("reset_dut3_busy_done", 32'({busy3, done3}), 32'd0);
      rst_n = 1'b1;

      // Zero results, with a start pulse mid-RUN that must be ignored.
      run_sweep(0, 50);
      chk("zero_sig", 32'(sig1), 32'd0);
      chk("zero_tog", 32'(tog1), 32'd0);

      run_sweep(1, 0);
      chk("final_sample_sig", 32'(sig1), 32'h0001);

      run_sweep(2, 0);
      chk("alternating_sig", 32'(sig1), 32'(alt_sig));
      chk("alternating_tog", 32'(tog1), TogEn ? 32'd1536 : 32'd0);

      run_sweep(3, 0);
      chk("model_sig", 32'(sig1), 32'(model_sig));
      chk("model_tog", 32'(tog1), TogEn ? 32'(model_tog) : 32'd0);

      // Asynchronous reset in the middle of a sweep.
      use_model = 1'b1;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (101) @(negedge clk);
      chk("pre_reset_idx", 32'({a1, b1}), 32'd100);
      rst_n = 1'b0;
      #1;
      chk("midrst_operands", 32'({a1, b1}), 32'd0);
      chk("midrst_busy_done", 32'({busy1, done1}), 32'd0);
      chk("midrst_sig", 32'(sig1), 32'd0);
      chk("midrst_tog", 32'(tog1), 32'd0);
      chk("midrst_dut3", 32'({busy3, done3, a3, b3}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(3, 0);
      chk("post_reset_sig", 32'(sig1), 32'(model_sig));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
